// File: rtl/flag_pkg.sv
// Shared definitions for the condition-flag unit: ARM condition codes and
// the bit positions of the flags inside the ALU/CPSR flags word.
package flag_pkg;

   typedef enum logic [3:0] {
      EQ = 4'd0,
      NE = 4'd1,
      CS = 4'd2,
      CC = 4'd3,
      MI = 4'd4,
      PL = 4'd5,
      VS = 4'd6,
      VC = 4'd7,
      HI = 4'd8,
      LS = 4'd9,
      GE = 4'd10,
      LT = 4'd11,
      GT = 4'd12,
      LE = 4'd13,
      AL = 4'd14,
      NV = 4'd15
   } cond_e;

   localparam int FLAG_N = 31;
   localparam int FLAG_Z = 30;
   localparam int FLAG_C = 29;
   localparam int FLAG_V = 28;
   localparam int CMP_LO = 16;
   localparam int CMP_HI = 19;

   localparam logic [31:0] FLAG_MASK = 32'hF00F_0000;

   // AL and NV are decided without looking at the flags, so they never wait on a writer.
   function automatic logic cond_needs_flags(input logic [3:0] code);
      return (code != AL) && (code != NV);
   endfunction

   function automatic logic [3:0] cmp_flags(input logic [31:0] word);
      return word[CMP_HI:CMP_LO];
   endfunction

endpackage

// File: rtl/cond_eval.sv
// Pure combinational ARM condition evaluator; flags_i is packed {N,Z,C,V}.
// Kept free of pipeline state so a branch unit can reuse it as-is.
module cond_eval
   import flag_pkg::*;
(
   input  logic [3:0] flags_i,
   input  logic [3:0] cond_i,
   output logic       pass_o
);

   logic n;
   logic z;
   logic c;
   logic v;

   assign n = flags_i[3];
   assign z = flags_i[2];
   assign c = flags_i[1];
   assign v = flags_i[0];

   always_comb begin
      pass_o = 1'b0;
      case (cond_e'(cond_i))
         EQ: pass_o = z;
         NE: pass_o = !z;
         CS: pass_o = c;
         CC: pass_o = !c;
         MI: pass_o = n;
         PL: pass_o = !n;
         VS: pass_o = v;
         VC: pass_o = !v;
         HI: pass_o = c && !z;
         LS: pass_o = !c || z;
         GE: pass_o = (n == v);
         LT: pass_o = (n != v);
         GT: pass_o = !z && (n == v);
         LE: pass_o = z || (n != v);
         AL: pass_o = 1'b1;
         NV: pass_o = 1'b0;
         default: pass_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_unit.sv
// Architectural condition flags, in-flight flag-writer tracking and the
// issue-side condition check with same-cycle writeback forwarding.
module flag_unit
   import flag_pkg::*;
#(
   parameter int MAX_PENDING = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               cond_valid,
   input  logic [3:0]                         cond_code,
   input  logic                               sets_flags,
   output logic                               cond_ready,
   output logic                               cond_pass,
   input  logic                               flags_valid,
   input  logic [31:0]                        flags_in,
   input  logic                               flush,
   output logic [31:0]                        cpsr_flags,
   output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
   output logic                               err_underflow
);

   localparam int CW = $clog2(MAX_PENDING + 1);
   localparam logic [CW-1:0] MAX_P = CW'(MAX_PENDING);
   localparam logic [CW-1:0] ONE   = CW'(1);

   logic [31:0]   cpsr_q;
   logic [31:0]   cpsr_d;
   logic [CW-1:0] pend_q;
   logic [CW-1:0] pend_d;
   logic          err_q;
   logic          err_d;

   logic [3:0]    nzcv;
   logic          needs_flags;
   logic          wb_dec;
   logic [CW-1:0] eff_pend;
   logic          accept;
   logic          issue_inc;
   logic          pass;

   // A writeback in this cycle is visible to the issuing instruction immediately.
   always_comb begin
      nzcv = {cpsr_q[FLAG_N], cpsr_q[FLAG_Z], cpsr_q[FLAG_C], cpsr_q[FLAG_V]};
      if (flags_valid) begin
         nzcv = {flags_in[FLAG_N], flags_in[FLAG_Z], flags_in[FLAG_C], flags_in[FLAG_V]};
      end
   end

   cond_eval u_cond_eval (
      .flags_i (nzcv),
      .cond_i  (cond_code),
      .pass_o  (pass)
   );

   always_comb begin
      needs_flags = cond_needs_flags(cond_code);
      wb_dec      = flags_valid && (pend_q != '0);
      eff_pend    = wb_dec ? (pend_q - ONE) : pend_q;
      cond_ready  = !flush
                    && (!needs_flags || (eff_pend == '0))
                    && (!sets_flags || (eff_pend < MAX_P));
      accept      = cond_valid && cond_ready;
      issue_inc   = accept && sets_flags && pass;
      cond_pass   = pass;
   end

   // Ready already guarantees room for the increment, so no saturation clamp is needed here.
   always_comb begin
      pend_d = pend_q;
      if (flush) begin
         pend_d = '0;
      end else begin
         case ({issue_inc, wb_dec})
            2'b10:   pend_d = pend_q + ONE;
            2'b01:   pend_d = pend_q - ONE;
            default: pend_d = pend_q;
         endcase
      end
   end

   always_comb begin
      cpsr_d = cpsr_q;
      if (flags_valid) begin
         cpsr_d = flags_in & FLAG_MASK;
      end
      err_d = flags_valid && (pend_q == '0) && !flush;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpsr_q <= '0;
         pend_q <= '0;
         err_q  <= 1'b0;
      end else begin
         cpsr_q <= cpsr_d;
         pend_q <= pend_d;
         err_q  <= err_d;
      end
   end

   assign cpsr_flags    = cpsr_q;
   assign pending       = pend_q;
   assign err_underflow = err_q;

endmodule

// File: doc/flag_unit.md
# flag_unit

Holds the CPU's architectural condition flags and decides whether each issuing instruction's 4-bit ARM condition passes. It sits between decode/issue and execute. It takes the 32-bit flags word produced by the ALU at writeback and stalls conditional issue while an older flag-setting instruction is still in flight. It forwards same-cycle writeback flags so that a dependent instruction issues without a bubble.

## Interface
Parameters:
- MAX_PENDING, 4: maximum number of in-flight flag-setting instructions; the counter is $clog2(MAX_PENDING+1) bits wide.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cond_valid  in  1  issue stage presents an instruction.
- cond_code  in  4  ARM condition field.
- sets_flags  in  1  the instruction has its S-bit set and will return a flags word.
- cond_ready  out  1  issue is accepted this cycle when both cond_valid and cond_ready are 1.
- cond_pass  out  1  condition result; valid only on an accepted issue.
- flags_valid  in  1  writeback delivers one flags word.
- flags_in  in  32  flags word in ALU layout:
  - bits 31, 30, 29, 28 are N, Z, C, V. The C slot carries ALU bit 29 unchanged.
  - bits 19:16 are the byte-compare flags.
  - all other bits are ignored.
- flush  in  1  pipeline squash: all in-flight flag writers are discarded.
- cpsr_flags  out  32  registered architectural flags in the same layout; unused bits are always 0.
- pending  out  counter width  number of in-flight flag writers.
- err_underflow  out  1  registered one-cycle pulse.

## Operation
- Condition evaluation (cond, pass condition):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: always passes
  - 15 NV: never passes
- Codes 0–13 need flags. Codes 14 and 15 never stall on flags.
- Source flags for evaluation are flags_in when flags_valid is 1 (forwarding), otherwise cpsr_flags.
- eff_pending = pending − flags_valid, computed without wrap; with pending==0 it stays 0.
- cond_ready is 1 only when all three hold:
  - flush is 0;
  - the code does not need flags, or eff_pending==0;
  - sets_flags is 0, or eff_pending < MAX_PENDING.
- A failed condition suppresses the flag write.
  - On an accepted issue with sets_flags=1 and cond_pass=1, the counter increments.
  - The pipeline sends no flags_valid for a failed instruction.
- On flags_valid, cpsr_flags bits {31:28,19:16} load from flags_in at the next edge.
- Counter next value:
  - flush: 0. Flush has priority over everything.
  - otherwise: pending + inc − dec, where inc comes from the accepted issue and dec from flags_valid.
  - simultaneous inc and dec: unchanged.
- flags_valid while flush is 1: cpsr_flags still update.
- Underflow: flags_valid with pending==0 and no flush.
  - cpsr_flags still update.
  - the counter stays 0.
  - err_underflow pulses on the next cycle.

## Timing
- Reset values: cpsr_flags=0, pending=0, err_underflow=0.
  - With Z=0 after reset, EQ fails and NE passes.
- cond_ready and cond_pass are combinational, same cycle, from cond_code, sets_flags, flush, flags_valid, flags_in and registered state.
- Zero-bubble forwarding: a conditional issue in the same cycle as the last pending writeback is accepted and evaluated on flags_in.
- cpsr_flags reflects a writeback one cycle after flags_valid.
- pending reflects an accepted issue one cycle later.
- An issue stalled with cond_ready=0 must keep cond_code and sets_flags stable.
- Reset asserted mid-stall clears all state immediately. cond_ready follows the cleared state combinationally.
- With pending==MAX_PENDING, a flag-setting AL issue is accepted only when flags_valid is 1 in the same cycle.

## Structure
- Package flag_pkg holds:
  - the cond_e enum (EQ..NV, 4 bits);
  - flag bit-index localparams: N=31, Z=30, C=29, V=28, CMP_LO=16, CMP_HI=19;
  - FLAG_MASK=32'hF00F_0000.
- Sub-module cond_eval: combinational, 4-bit N/Z/C/V plus cond_code in, pass out. It is reusable by a future branch unit.
- The top level holds:
  - the flags register;
  - the saturating pending counter;
  - the ready logic;
  - the error pulse flop.

## Test plan
- Reset, then issue cond=0 (EQ) with sets_flags=0: cond_ready=1, cond_pass=0. Issue cond=1 (NE): cond_pass=1. pending stays 0.
- Issue cond=14 (AL) with sets_flags=1, then cond=0 (EQ) next cycle with flags_valid=0:
  - cond_ready=0 while pending=1.
  - then flags_valid=1 with flags_in=32'h4000_0000 in the same cycle: EQ is accepted with cond_pass=1.
  - cpsr_flags=32'h4000_0000 one cycle later, pending=0.
- GE/LT/GT/LE check with flags_in=32'h9000_0000 (N=1, V=1): GE passes, LT fails, GT passes, LE fails.
  - repeat with 32'h8000_0000: GE fails, LT passes.
- Fill MAX_PENDING=4 with AL flag-setters: pending=4. A fifth flag-setter has cond_ready=0. The same issue with flags_valid=1 is accepted and pending stays 4. Then assert flush: cond_ready=0 that cycle, pending=0 next cycle.
- flags_valid with flags_in=32'hFFFF_FFFF at pending=0:
  - cpsr_flags=32'hF00F_0000 next cycle;
  - err_underflow=1 for exactly one cycle;
  - pending stays 0.
- Issue a failing flag-setter, cond=0 (EQ) with Z=0 and sets_flags=1: accepted with cond_pass=0, pending stays 0.
  - Then assert rst asynchronously with pending=2: pending=0 and cpsr_flags=0 immediately.
